ex_csr_rmw: RTL and testbench
=============================

Name: ex_csr_rmw

Overview:
- Parametrised successor to the execute-stage CSR unit.
- Performs each Zicsr instruction as a sequenced read-modify-write against the CSR register file:
  - valid/ready handshake with the issue stage
  - registered read of the old value
  - computed write-back
- Adds the behaviour the previous unit lacked:
  - old-value return to rd
  - RISC-V write-suppression rules
  - read-only CSR illegal detection
  - configurable width

Parameters:
XLEN, 64, data width of rs1, CSR values and rd result
CSR_AW, 12, CSR address width
ZIMM_W, 5, width of the uimm field, zero-extended to XLEN

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
valid_i  input  1  issue stage presents a CSR instruction
ready_o  output  1  unit can accept an instruction this cycle
csr_op_i  input  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI, 000/100 no-op
csr_addr_i  input  CSR_AW  target CSR
rs1_idx_i  input  5  rs1 register index (used for the suppression rule)
rs1_data_i  input  XLEN  rs1 value
zimm_i  input  ZIMM_W  immediate operand
rd_idx_i  input  5  destination register
csr_rd_addr_o  output  CSR_AW  read address to CSR file
csr_rd_data_i  input  XLEN  combinational read data from CSR file
csr_we_o  output  1  CSR write strobe
csr_wr_addr_o  output  CSR_AW  CSR write address
csr_wr_data_o  output  XLEN  CSR write data
rd_valid_o  output  1  one-cycle pulse: rd write-back valid
rd_idx_o  output  5  rd index for write-back
rd_data_o  output  XLEN  old CSR value
illegal_o  output  1  one-cycle pulse: write to read-only CSR
busy_o  output  1  an instruction is in flight

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- Reset: state IDLE. ready_o=1, busy_o=0. csr_we_o, rd_valid_o and illegal_o are 0. All data/address outputs and internal latches are 0.
- FSM states: IDLE, READ, WRITE.
- IDLE:
  - ready_o=1.
  - On valid_i&ready_o, latch op, addr, operand and rd_idx, then go to READ.
  - operand = rs1_data_i for op[2]=0; zero-extend(zimm_i) for op[2]=1.
- READ:
  - csr_rd_addr_o=latched addr.
  - Capture csr_rd_data_i into old_q, then go to WRITE.
  - ready_o=0.
- WRITE:
  - Compute new value: RW/RWI = operand; RS/RSI = old_q|operand; RC/RCI = old_q&~operand.
  - Write is suppressed, but the read still occurs, when any of:
    - op is a no-op
    - RS/RC with rs1_idx==0
    - RSI/RCI with zimm==0
  - Read-only CSR: addr[CSR_AW-1:CSR_AW-2]==2'b11. An unsuppressed write to it gives illegal_o=1, csr_we_o=0, rd_valid_o=0.
  - Otherwise:
    - csr_we_o=1 if the write is not suppressed.
    - rd_valid_o=1 if rd_idx!=0 and op is not a no-op.
    - rd_data_o=old_q.
  - Next state IDLE.
- Strobes (csr_we_o, rd_valid_o, illegal_o) are high for exactly the one WRITE cycle.
- Timing:
  - Latency: accept cycle N, write/rd pulse in cycle N+2.
  - Throughput: one instruction per 3 cycles (see optional feature).
- busy_o = (state!=IDLE).
- valid_i while ready_o=0 is ignored. The issue stage must hold the instruction until accepted.
- rst asserted in READ or WRITE: return to IDLE next edge with no write or pulse issued in that cycle.
- Arithmetic is bitwise only over XLEN. No carries, no truncation.

Optional Feature:
- Macro: CSR_BYPASS_EN
- Defined:
  - ready_o is also 1 in WRITE, so a new instruction can be accepted while the previous one writes.
  - The accept-cycle then goes to READ; sustained rate is one instruction per 2 cycles.
  - If the following READ addresses the CSR written in the immediately preceding WRITE cycle, old_q takes the forwarded write data instead of csr_rd_data_i.
- Undefined:
  - ready_o only in IDLE.
  - No forwarding path exists.

Test Plan:
- Reset, then CSRRW addr 0x340, rs1=0xDEAD_BEEF, rd=5, file holds 0x1234 -> cycle N+2: csr_we_o=1, wr_data 0xDEADBEEF, rd_valid_o=1, rd_idx 5, rd_data 0x1234.
- CSRRS addr 0x300, rs1_idx=0, file 0x88 -> csr_we_o=0, rd_valid_o=1, rd_data 0x88. Same with rs1_idx=3, rs1=0x0F -> wr_data 0x8F.
- CSRRCI addr 0x300, zimm=5'b01000, file 0xFF -> wr_data 0xF7. CSRRSI with zimm=0 -> no write.
- CSRRW to addr 0xC00 -> illegal_o=1 one cycle, csr_we_o=0, rd_valid_o=0. CSRRS to 0xC00 with rs1_idx=0 -> legal read, rd_valid_o=1.
- rst asserted in READ -> next cycle IDLE, ready_o=1, no csr_we_o ever pulses for that instruction.
- With CSR_BYPASS_EN: back-to-back CSRRW 0x340<-0xA then CSRRS 0x340 rs1=0x5 -> second rd_data 0xA, wr_data 0xF. Accept interval is 2 cycles.

Source files
------------

// File: rtl/ex_csr_rmw.sv
// Execute-stage Zicsr unit: each instruction runs IDLE -> READ -> WRITE against the CSR file.
// Optional macro CSR_BYPASS_EN overlaps the next accept with WRITE and forwards the fresh write data.
module ex_csr_rmw #(
  parameter int XLEN   = 64,
  parameter int CSR_AW = 12,
  parameter int ZIMM_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        csr_op_i,
  input  logic [CSR_AW-1:0] csr_addr_i,
  input  logic [4:0]        rs1_idx_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [ZIMM_W-1:0] zimm_i,
  input  logic [4:0]        rd_idx_i,
  output logic [CSR_AW-1:0] csr_rd_addr_o,
  input  logic [XLEN-1:0]   csr_rd_data_i,
  output logic              csr_we_o,
  output logic [CSR_AW-1:0] csr_wr_addr_o,
  output logic [XLEN-1:0]   csr_wr_data_o,
  output logic              rd_valid_o,
  output logic [4:0]        rd_idx_o,
  output logic [XLEN-1:0]   rd_data_o,
  output logic              illegal_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t            state;
  logic [1:0]        op_q;
  logic [CSR_AW-1:0] addr_q;
  logic [XLEN-1:0]   operand_q;
  logic [4:0]        rd_idx_q;
  logic              supp_q;
  logic [XLEN-1:0]   old_q;
  logic [XLEN-1:0]   wr_data_q;
  logic              we_q;
  logic              rdv_q;
  logic              ill_q;
  logic              ready_q;
`ifdef CSR_BYPASS_EN
  logic              fwd_q;
`endif

  logic              accept;
  logic [XLEN-1:0]   operand_in;
  logic              supp_in;
  logic [XLEN-1:0]   read_val;
  logic [XLEN-1:0]   new_val;
  logic              read_only;

  assign accept     = valid_i && ready_q;
  assign operand_in = csr_op_i[2] ? {{(XLEN-ZIMM_W){1'b0}}, zimm_i} : rs1_data_i;
  assign read_only  = (addr_q[CSR_AW-1 -: 2] == 2'b11);

  // Suppression is decided at accept so rs1_idx/zimm need not be held.
  always_comb begin
    supp_in = 1'b0;
    case (csr_op_i)
      3'b000, 3'b100: supp_in = 1'b1;
      3'b010, 3'b011: supp_in = (rs1_idx_i == 5'd0);
      3'b110, 3'b111: supp_in = (zimm_i == '0);
      default:        supp_in = 1'b0;
    endcase
  end

  always_comb begin
`ifdef CSR_BYPASS_EN
    read_val = fwd_q ? wr_data_q : csr_rd_data_i;
`else
    read_val = csr_rd_data_i;
`endif
    case (op_q)
      2'b01:   new_val = operand_q;
      2'b10:   new_val = read_val | operand_q;
      2'b11:   new_val = read_val & ~operand_q;
      default: new_val = read_val;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      operand_q <= '0;
      rd_idx_q  <= '0;
      supp_q    <= 1'b0;
      old_q     <= '0;
      wr_data_q <= '0;
      we_q      <= 1'b0;
      rdv_q     <= 1'b0;
      ill_q     <= 1'b0;
      ready_q   <= 1'b1;
`ifdef CSR_BYPASS_EN
      fwd_q     <= 1'b0;
`endif
    end else begin
      we_q  <= 1'b0;
      rdv_q <= 1'b0;
      ill_q <= 1'b0;
      if (accept) begin
        op_q      <= csr_op_i[1:0];
        addr_q    <= csr_addr_i;
        operand_q <= operand_in;
        rd_idx_q  <= rd_idx_i;
        supp_q    <= supp_in;
        state     <= READ;
        ready_q   <= 1'b0;
`ifdef CSR_BYPASS_EN
        // Only a write actually issued this cycle is worth forwarding.
        fwd_q     <= we_q && (csr_addr_i == addr_q);
`endif
      end else begin
        case (state)
          READ: begin
            old_q     <= read_val;
            wr_data_q <= new_val;
            we_q      <= !supp_q && !read_only;
            ill_q     <= !supp_q && read_only;
            rdv_q     <= !(!supp_q && read_only) && (rd_idx_q != 5'd0) && (op_q != 2'b00);
            state     <= WRITE;
`ifdef CSR_BYPASS_EN
            ready_q   <= 1'b1;
`endif
          end
          WRITE: begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Strobes are masked by rst so a reset landing on WRITE issues nothing.
  assign csr_we_o      = we_q && !rst;
  assign rd_valid_o    = rdv_q && !rst;
  assign illegal_o     = ill_q && !rst;
  assign ready_o       = ready_q;
  assign busy_o        = (state != IDLE);
  assign csr_rd_addr_o = addr_q;
  assign csr_wr_addr_o = addr_q;
  assign csr_wr_data_o = wr_data_q;
  assign rd_idx_o      = rd_idx_q;
  assign rd_data_o     = old_q;

endmodule

// File: tb/tb_ex_csr_rmw.sv
// Bench for ex_csr_rmw: CSR file model, transaction-level reference model and per-cycle checker.
// Accept-interval expectation follows CSR_BYPASS_EN when the bench is built with it.
module tb_ex_csr_rmw;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic [4:0]  rs1_idx_i;
  logic [63:0] rs1_data_i;
  logic [4:0]  zimm_i;
  logic [4:0]  rd_idx_i;
  logic [11:0] csr_rd_addr_o;
  logic [63:0] csr_rd_data_i;
  logic        csr_we_o;
  logic [11:0] csr_wr_addr_o;
  logic [63:0] csr_wr_data_o;
  logic        rd_valid_o;
  logic [4:0]  rd_idx_o;
  logic [63:0] rd_data_o;
  logic        illegal_o;
  logic        busy_o;

  ex_csr_rmw #(.XLEN(64), .CSR_AW(12), .ZIMM_W(5)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i), .rs1_idx_i(rs1_idx_i),
    .rs1_data_i(rs1_data_i), .zimm_i(zimm_i), .rd_idx_i(rd_idx_i),
    .csr_rd_addr_o(csr_rd_addr_o), .csr_rd_data_i(csr_rd_data_i),
    .csr_we_o(csr_we_o), .csr_wr_addr_o(csr_wr_addr_o), .csr_wr_data_o(csr_wr_data_o),
    .rd_valid_o(rd_valid_o), .rd_idx_o(rd_idx_o), .rd_data_o(rd_data_o),
    .illegal_o(illegal_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        we;
    logic [11:0] addr;
    logic [63:0] wd;
    logic        rdv;
    logic [4:0]  rd;
    logic [63:0] old;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] csr_mem   [4096];
  logic [63:0] model_mem [4096];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_txn = 0;
  bit          chk_en = 0;
  int          acc_cyc = 0;
  int          acc_cyc_prev = 0;
  logic        preset_en = 1'b0;
  logic [11:0] preset_addr = '0;
  logic [63:0] preset_val = '0;
  logic        last_we, last_rdv, last_ill;
  logic [63:0] last_wd, last_rdd;
  logic [4:0]  last_rd;

  // CSR file: combinational read, write on the clock edge.
  assign csr_rd_data_i = csr_mem[csr_rd_addr_o];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (preset_en) csr_mem[preset_addr] <= preset_val;
    else if (csr_we_o) csr_mem[csr_wr_addr_o] <= csr_wr_data_o;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle checker: strobes must match the expected transaction at N+2 and be quiet otherwise.
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        n_txn++;
        chk("csr_we", 64'(csr_we_o), 64'(e.we));
        if (e.we) begin
          chk("wr_addr", 64'(csr_wr_addr_o), 64'(e.addr));
          chk("wr_data", csr_wr_data_o, e.wd);
        end
        chk("rd_valid", 64'(rd_valid_o), 64'(e.rdv));
        if (e.rdv) begin
          chk("rd_idx", 64'(rd_idx_o), 64'(e.rd));
          chk("rd_data", rd_data_o, e.old);
        end
        chk("illegal", 64'(illegal_o), 64'(e.ill));
        last_we  = csr_we_o;
        last_wd  = csr_wr_data_o;
        last_rdv = rd_valid_o;
        last_rd  = rd_idx_o;
        last_rdd = rd_data_o;
        last_ill = illegal_o;
        $display("txn %0d cyc %0d addr %h we %0b wd %h rdv %0b rd %0d old %h ill %0b",
                 n_txn, cyc, e.addr, csr_we_o, csr_wr_data_o, rd_valid_o, rd_idx_o,
                 rd_data_o, illegal_o);
      end else begin
        chk("quiet_strobes", 64'({csr_we_o, rd_valid_o, illegal_o}), 64'd0);
      end
    end
  end

  task automatic set_csr(input logic [11:0] a, input logic [63:0] v);
    @(negedge clk);
    preset_en   = 1'b1;
    preset_addr = a;
    preset_val  = v;
    model_mem[a] = v;
    @(posedge clk);
    #1 preset_en = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [11:0] addr, input logic [4:0] r1i,
                       input logic [63:0] r1, input logic [4:0] zi, input logic [4:0] rd,
                       input bit expect_it);
    int n;
    exp_t e;
    logic [63:0] opd, oldv, newv;
    logic noop, supp, ro;
    @(negedge clk);
    csr_op_i = op; csr_addr_i = addr; rs1_idx_i = r1i; rs1_data_i = r1;
    zimm_i = zi; rd_idx_i = rd; valid_i = 1'b1;
    n = 0;
    while (!ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept", 64'(ready_o), 64'd1);
    if (!ready_o) begin
      valid_i = 1'b0;
      return;
    end
    acc_cyc_prev = acc_cyc;
    acc_cyc = cyc;
    if (expect_it) begin
      oldv = model_mem[addr];
      opd  = op[2] ? {59'd0, zi} : r1;
      case (op[1:0])
        2'b01:   newv = opd;
        2'b10:   newv = oldv | opd;
        2'b11:   newv = oldv & ~opd;
        default: newv = oldv;
      endcase
      noop  = (op[1:0] == 2'b00);
      supp  = noop || (op[1] && !op[2] && r1i == 5'd0) || (op[1] && op[2] && zi == 5'd0);
      ro    = (addr[11:10] == 2'b11);
      e.cyc = cyc + 2;
      e.ill = !supp && ro;
      e.we  = !supp && !ro;
      e.rdv = !e.ill && (rd != 5'd0) && !noop;
      e.addr = addr; e.wd = newv; e.rd = rd; e.old = oldv;
      if (e.we) model_mem[addr] = newv;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_o && n < 20);
    chk("idle", 64'(busy_o), 64'd0);
  endtask

  logic [11:0] addrs [6];
  int          exp_gap;

  initial begin
    rst = 1'b1; valid_i = 1'b0; csr_op_i = '0; csr_addr_i = '0; rs1_idx_i = '0;
    rs1_data_i = '0; zimm_i = '0; rd_idx_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_strobes", 64'({csr_we_o, rd_valid_o, illegal_o}), 64'd0);
    chk("rst_wr_data", csr_wr_data_o, 64'd0);
    chk("rst_rd_data", rd_data_o, 64'd0);
    chk("rst_addrs", 64'({csr_rd_addr_o, csr_wr_addr_o, rd_idx_o}), 64'd0);
    chk_en = 1;

    // CSRRW 0x340
    set_csr(12'h340, 64'h1234);
    issue(3'b001, 12'h340, 5'd1, 64'hDEAD_BEEF, 5'd0, 5'd5, 1);
    wait_idle();
    chk("rw_we", 64'(last_we), 64'd1);
    chk("rw_wd", last_wd, 64'hDEAD_BEEF);
    chk("rw_rdv", 64'(last_rdv), 64'd1);
    chk("rw_rd", 64'(last_rd), 64'd5);
    chk("rw_old", last_rdd, 64'h1234);

    // CSRRS with rs1=x0 then with rs1=x3
    set_csr(12'h300, 64'h88);
    issue(3'b010, 12'h300, 5'd0, 64'h1234_5678, 5'd0, 5'd6, 1);
    wait_idle();
    chk("rs_x0_we", 64'(last_we), 64'd0);
    chk("rs_x0_rdv", 64'(last_rdv), 64'd1);
    chk("rs_x0_old", last_rdd, 64'h88);
    issue(3'b010, 12'h300, 5'd3, 64'h0F, 5'd0, 5'd6, 1);
    wait_idle();
    chk("rs_we", 64'(last_we), 64'd1);
    chk("rs_wd", last_wd, 64'h8F);

    // CSRRCI / CSRRSI zimm=0
    set_csr(12'h300, 64'hFF);
    issue(3'b111, 12'h300, 5'd0, 64'd0, 5'b01000, 5'd7, 1);
    wait_idle();
    chk("rci_we", 64'(last_we), 64'd1);
    chk("rci_wd", last_wd, 64'hF7);
    issue(3'b110, 12'h300, 5'd9, 64'hFFFF, 5'd0, 5'd7, 1);
    wait_idle();
    chk("rsi_z0_we", 64'(last_we), 64'd0);

    // Read-only CSR
    set_csr(12'hC00, 64'h42);
    issue(3'b001, 12'hC00, 5'd4, 64'h77, 5'd0, 5'd8, 1);
    wait_idle();
    chk("ro_ill", 64'(last_ill), 64'd1);
    chk("ro_we", 64'(last_we), 64'd0);
    chk("ro_rdv", 64'(last_rdv), 64'd0);
    issue(3'b010, 12'hC00, 5'd0, 64'h77, 5'd0, 5'd9, 1);
    wait_idle();
    chk("ro_read_ill", 64'(last_ill), 64'd0);
    chk("ro_read_rdv", 64'(last_rdv), 64'd1);
    chk("ro_read_old", last_rdd, 64'h42);

    // Reset while in READ: the instruction must vanish
    issue(3'b001, 12'h340, 5'd1, 64'h5555, 5'd0, 5'd7, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rstread_ready", 64'(ready_o), 64'd1);
    chk("rstread_busy", 64'(busy_o), 64'd0);
    repeat (4) @(negedge clk);
    chk("rstread_mem", csr_mem[12'h340], model_mem[12'h340]);

    // Back-to-back accept interval
    issue(3'b001, 12'h340, 5'd1, 64'hA, 5'd0, 5'd1, 1);
    issue(3'b010, 12'h340, 5'd2, 64'h5, 5'd0, 5'd2, 1);
`ifdef CSR_BYPASS_EN
    exp_gap = 2;
`else
    exp_gap = 3;
`endif
    chk("accept_interval", 64'(acc_cyc - acc_cyc_prev), 64'(exp_gap));
    wait_idle();
    chk("b2b_old", last_rdd, 64'hA);
    chk("b2b_wd", last_wd, 64'hF);

    // Randomized traffic
    addrs[0] = 12'h340; addrs[1] = 12'h300; addrs[2] = 12'h305;
    addrs[3] = 12'hC00; addrs[4] = 12'hF11; addrs[5] = 12'h7C0;
    for (int i = 0; i < 6; i++) set_csr(addrs[i], {$urandom, $urandom});
    for (int i = 0; i < 200; i++) begin
      logic [4:0] r1i, zi, rd;
      r1i = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      zi  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      issue(3'($urandom_range(0, 7)), addrs[$urandom_range(0, 5)], r1i,
            {$urandom, $urandom}, zi, rd, 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 6; i++) chk("final_mem", csr_mem[addrs[i]], model_mem[addrs[i]]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
